// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b datapath and memory-arbiter types
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_c_block;

   // Arbiter grant state, exported so debug probes can decode it by name.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      I_GNT = 2'd1,
      D_GNT = 2'd2
   } lc3b_arb_state;

endpackage

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - round-robin icache/dcache arbiter for the physical-memory port
module pmem_arbiter
   import lc3b_types::*;
#(
   parameter int WATCHDOG = 1023
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        icache_pmem_read,
   input  lc3b_word    icache_pmem_address,
   output logic        icache_pmem_resp,
   output lc3b_c_block icache_pmem_rdata,

   input  logic        dcache_pmem_read,
   input  logic        dcache_pmem_write,
   input  lc3b_word    dcache_pmem_address,
   input  lc3b_c_block dcache_pmem_wdata,
   output logic        dcache_pmem_resp,
   output lc3b_c_block dcache_pmem_rdata,

   output logic        pmem_read,
   output logic        pmem_write,
   output lc3b_word    pmem_address,
   output lc3b_c_block pmem_wdata,
   input  lc3b_c_block pmem_rdata,
   input  logic        pmem_resp,

   output logic        ld_regs,
   output logic        pmem_err
);

   localparam int WD_W = (WATCHDOG > 0) ? $clog2(WATCHDOG + 1) : 1;
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG);

   lc3b_arb_state   state;
   lc3b_arb_state   next_state;
   logic            last_d;
   logic [WD_W-1:0] wd_cnt;

   logic ireq;
   logic dreq;
   logic granted;

   assign ireq    = icache_pmem_read;
   assign dreq    = dcache_pmem_read | dcache_pmem_write;
   assign granted = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Ties go to whichever side was not served last; a grant always returns
   // through IDLE so the other side gets a fair sampling edge.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (ireq && dreq) begin
               next_state = last_d ? I_GNT : D_GNT;
            end else if (ireq) begin
               next_state = I_GNT;
            end else if (dreq) begin
               next_state = D_GNT;
            end
         end
         I_GNT, D_GNT: begin
            if (pmem_resp) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      unique case (state)
         I_GNT: begin
            pmem_read    = 1'b1;
            pmem_address = icache_pmem_address;
         end
         D_GNT: begin
            pmem_read    = dcache_pmem_read;
            pmem_write   = dcache_pmem_write;
            pmem_address = dcache_pmem_address;
            pmem_wdata   = dcache_pmem_wdata;
         end
         default: ;
      endcase
   end

   assign icache_pmem_resp  = pmem_resp & (state == I_GNT);
   assign dcache_pmem_resp  = pmem_resp & (state == D_GNT);
   assign icache_pmem_rdata = pmem_rdata;
   assign dcache_pmem_rdata = pmem_rdata;
   assign ld_regs           = (state == IDLE) & ~ireq & ~dreq;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_d <= 1'b1;
      end else if (granted && pmem_resp) begin
         last_d <= (state == D_GNT);
      end
   end

   // Counter is held at zero while idle, so every grant starts from a clean
   // count; the flag only records the hang, the grant itself is never revoked.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt   <= '0;
         pmem_err <= 1'b0;
      end else if (!granted) begin
         wd_cnt <= '0;
      end else if (!pmem_resp) begin
         if (wd_cnt != WD_LIMIT) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
         if ((WATCHDOG != 0) && ((wd_cnt + 1'b1) == WD_LIMIT)) begin
            pmem_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - scoreboard bench for pmem_arbiter
module tb_pmem_arbiter;
   import lc3b_types::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        icache_pmem_read;
   lc3b_word    icache_pmem_address;
   logic        icache_pmem_resp;
   lc3b_c_block icache_pmem_rdata;
   logic        dcache_pmem_read;
   logic        dcache_pmem_write;
   lc3b_word    dcache_pmem_address;
   lc3b_c_block dcache_pmem_wdata;
   logic        dcache_pmem_resp;
   lc3b_c_block dcache_pmem_rdata;
   logic        pmem_read;
   logic        pmem_write;
   lc3b_word    pmem_address;
   lc3b_c_block pmem_wdata;
   lc3b_c_block pmem_rdata;
   logic        pmem_resp;
   logic        ld_regs;
   logic        pmem_err;

   pmem_arbiter #(.WATCHDOG(8)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .icache_pmem_read    (icache_pmem_read),
      .icache_pmem_address (icache_pmem_address),
      .icache_pmem_resp    (icache_pmem_resp),
      .icache_pmem_rdata   (icache_pmem_rdata),
      .dcache_pmem_read    (dcache_pmem_read),
      .dcache_pmem_write   (dcache_pmem_write),
      .dcache_pmem_address (dcache_pmem_address),
      .dcache_pmem_wdata   (dcache_pmem_wdata),
      .dcache_pmem_resp    (dcache_pmem_resp),
      .dcache_pmem_rdata   (dcache_pmem_rdata),
      .pmem_read           (pmem_read),
      .pmem_write          (pmem_write),
      .pmem_address        (pmem_address),
      .pmem_wdata          (pmem_wdata),
      .pmem_rdata          (pmem_rdata),
      .pmem_resp           (pmem_resp),
      .ld_regs             (ld_regs),
      .pmem_err            (pmem_err)
   );

   typedef struct {
      logic        side;
      lc3b_word    addr;
      logic        wr;
      lc3b_c_block wdata;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   logic cur_v;

   int   n_err = 0;
   int   n_chk = 0;
   int   i_left, d_left, mem_lat, mcnt;
   logic d_wr, mem_en, chk_ld0;
   logic s_cmd, s_presp, s_iresp, s_dresp;
   lc3b_word s_addr;

   function automatic lc3b_c_block pat(input lc3b_word a);
      return {8{a}} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
   endfunction

   function automatic exp_t mk(input logic side, input lc3b_word addr,
                               input logic wr, input lc3b_c_block wdata);
      exp_t e;
      e.side  = side;
      e.addr  = addr;
      e.wr    = wr;
      e.wdata = wdata;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic monitor();
      logic cmd;
      cmd = pmem_read | pmem_write;
      if (cmd && (!s_cmd || s_presp)) begin
         chk("turnaround", s_presp, 1'b0);
         if (exp_q.size() == 0) begin
            chk("unexpected_grant", cmd, 1'b0);
            cur_v = 1'b0;
         end else begin
            cur   = exp_q.pop_front();
            cur_v = 1'b1;
         end
      end
      if (cmd && cur_v) begin
         chk("addr", pmem_address, cur.addr);
         chk("write", pmem_write, cur.wr);
         chk("read", pmem_read, !cur.wr);
         if (cur.wr) chk("wdata", pmem_wdata, cur.wdata);
      end
      if (icache_pmem_resp || dcache_pmem_resp) begin
         chk("resp_valid", cur_v, 1'b1);
         chk("iresp_side", icache_pmem_resp, cur_v && !cur.side);
         chk("dresp_side", dcache_pmem_resp, cur_v && cur.side);
         chk("irdata", icache_pmem_rdata, pat(cur.addr));
         chk("drdata", dcache_pmem_rdata, pat(cur.addr));
      end
      if (chk_ld0 && (i_left + d_left > 0)) chk("ld_regs_busy", ld_regs, 1'b0);
      s_cmd   = cmd;
      s_presp = pmem_resp;
      s_iresp = icache_pmem_resp;
      s_dresp = dcache_pmem_resp;
      s_addr  = pmem_address;
   endtask

   // Memory and cache models advance just after the rising edge; sampling is on the falling edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (pmem_resp) begin
         pmem_resp = 1'b0;
         mcnt      = 0;
      end else if (mem_en && s_cmd) begin
         mcnt++;
         if (mcnt >= mem_lat) begin
            pmem_resp  = 1'b1;
            pmem_rdata = pat(s_addr);
         end
      end
      if (s_iresp) begin
         i_left--;
         icache_pmem_address += 16'h0010;
         icache_pmem_read = (i_left > 0);
      end
      if (s_dresp) begin
         d_left--;
         dcache_pmem_address += 16'h0010;
         dcache_pmem_read  = (d_left > 0) && !d_wr;
         dcache_pmem_write = (d_left > 0) && d_wr;
      end
      @(negedge clk);
      monitor();
   endtask

   task automatic run_done(input int budget);
      int n = 0;
      while ((i_left > 0 || d_left > 0) && n < budget) begin
         step();
         n++;
      end
      chk("done_in_budget", (i_left == 0) && (d_left == 0), 1'b1);
      step();
      step();
      chk("queue_drained", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      icache_pmem_read  = 1'b0;
      dcache_pmem_read  = 1'b0;
      dcache_pmem_write = 1'b0;
      pmem_resp = 1'b0;
      mcnt   = 0;
      i_left = 0;
      d_left = 0;
      cur_v  = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      icache_pmem_read = 1'b0;  icache_pmem_address = '0;
      dcache_pmem_read = 1'b0;  dcache_pmem_write = 1'b0;
      dcache_pmem_address = '0; dcache_pmem_wdata = '0;
      pmem_rdata = '0; pmem_resp = 1'b0;
      i_left = 0; d_left = 0; d_wr = 1'b0; mem_en = 1'b1; mem_lat = 5; mcnt = 0;
      chk_ld0 = 1'b0; cur_v = 1'b0;
      s_cmd = 1'b0; s_presp = 1'b0; s_iresp = 1'b0; s_dresp = 1'b0; s_addr = '0;

      do_reset();
      chk("rst_read", pmem_read, 1'b0);
      chk("rst_write", pmem_write, 1'b0);
      chk("rst_addr", pmem_address, 16'h0000);
      chk("rst_ld_regs", ld_regs, 1'b1);
      chk("rst_err", pmem_err, 1'b0);

      // Lone icache fill
      icache_pmem_address = 16'h0040;
      exp_q.push_back(mk(1'b0, 16'h0040, 1'b0, '0));
      i_left = 1;
      icache_pmem_read = 1'b1;
      #1;
      chk("ld_regs_pending", ld_regs, 1'b0);
      step();
      chk("lat_read", pmem_read, 1'b1);
      chk("lat_addr", pmem_address, 16'h0040);
      run_done(40);
      chk("idle_ld_regs", ld_regs, 1'b1);

      // Simultaneous requests from reset: icache first
      do_reset();
      icache_pmem_address = 16'h0080;
      dcache_pmem_address = 16'h1000;
      d_wr = 1'b0;
      exp_q.push_back(mk(1'b0, 16'h0080, 1'b0, '0));
      exp_q.push_back(mk(1'b1, 16'h1000, 1'b0, '0));
      i_left = 1; d_left = 1;
      icache_pmem_read = 1'b1;
      dcache_pmem_read = 1'b1;
      run_done(60);

      // Dcache writeback
      dcache_pmem_address = 16'h2000;
      dcache_pmem_wdata   = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
      d_wr = 1'b1;
      exp_q.push_back(mk(1'b1, 16'h2000, 1'b1, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF));
      d_left = 1;
      dcache_pmem_write = 1'b1;
      run_done(40);

      // Continuous contention: I, D, I, D, I, D
      icache_pmem_address = 16'h0100;
      dcache_pmem_address = 16'h3000;
      d_wr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(mk(1'b0, 16'h0100 + 16'(k * 16), 1'b0, '0));
         exp_q.push_back(mk(1'b1, 16'h3000 + 16'(k * 16), 1'b0, '0));
      end
      i_left = 3; d_left = 3;
      chk_ld0 = 1'b1;
      icache_pmem_read = 1'b1;
      dcache_pmem_read = 1'b1;
      run_done(200);
      chk_ld0 = 1'b0;
      chk("no_err_normal", pmem_err, 1'b0);

      // Hung memory trips the watchdog after 8 granted cycles
      mem_en = 1'b0;
      icache_pmem_address = 16'h0500;
      exp_q.push_back(mk(1'b0, 16'h0500, 1'b0, '0));
      i_left = 1;
      icache_pmem_read = 1'b1;
      for (int k = 0; k < 8; k++) step();
      chk("wd_pre", pmem_err, 1'b0);
      step();
      chk("wd_set", pmem_err, 1'b1);
      for (int k = 0; k < 4; k++) step();
      chk("wd_sticky", pmem_err, 1'b1);
      chk("wd_grant_held", pmem_read, 1'b1);
      rst = 1'b1;
      icache_pmem_read = 1'b0;
      i_left = 0;
      cur_v = 1'b0;
      step();
      chk("wd_rst_clear", pmem_err, 1'b0);
      chk("wd_rst_idle", pmem_read, 1'b0);
      chk("wd_rst_iresp", icache_pmem_resp, 1'b0);
      rst = 1'b0;
      step();
      chk("wd_after_ld_regs", ld_regs, 1'b1);

      // Reset mid dcache read, then a stray response in IDLE
      dcache_pmem_address = 16'h4000;
      d_wr = 1'b0;
      exp_q.push_back(mk(1'b1, 16'h4000, 1'b0, '0));
      d_left = 1;
      dcache_pmem_read = 1'b1;
      step();
      step();
      chk("rd_granted", pmem_read, 1'b1);
      rst = 1'b1;
      dcache_pmem_read = 1'b0;
      d_left = 0;
      cur_v = 1'b0;
      step();
      chk("rst_mid_read", pmem_read, 1'b0);
      rst = 1'b0;
      step();
      pmem_rdata = pat(16'h4000);
      pmem_resp  = 1'b1;
      #1;
      chk("late_iresp", icache_pmem_resp, 1'b0);
      chk("late_dresp", dcache_pmem_resp, 1'b0);
      step();
      chk("late_idle", pmem_read, 1'b0);
      chk("late_ld_regs", ld_regs, 1'b1);
      chk("queue_final", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
